// File: rtl/vpat_pkg.sv
// Shared types and constants for the video pattern source.
//   mode_t      - pattern selector held in CTRL[2:1]
//   state_t     - frame sequencer states
//   pat_cfg_t   - pattern configuration latched once per frame
//   beat_t      - one Avalon-ST beat (data + packet markers)
//   ADDR_*      - Avalon-MM word addresses of the register file
package vpat_pkg;

  localparam int unsigned DATA_W = 24;
  localparam int unsigned CSR_W  = 32;
  localparam int unsigned ADDR_W = 3;

  typedef enum logic [1:0] {
    SOLID    = 2'd0,
    STRIPE   = 2'd1,
    GRADIENT = 2'd2,
    CHECKER  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    PIXELS = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_CTRL        = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_COLOR       = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_STRIPE_X    = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_FRAME_COUNT = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_STATUS      = 3'd4;

  localparam logic [DATA_W-1:0] COLOR_RST  = 24'hFF_FFFF;
  localparam logic [15:0]       STRIPE_RST = 16'd31;

  typedef struct packed {
    mode_t             mode;
    logic [DATA_W-1:0] color;
    logic [15:0]       stripe_x;
  } pat_cfg_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
  } beat_t;

  // Pixel value at (x, y) for a given pattern configuration.
  function automatic logic [DATA_W-1:0] pattern_pixel(input pat_cfg_t   cfg,
                                                      input logic [15:0] x,
                                                      input logic [7:0]  y);
    logic [DATA_W-1:0] pix;
    case (cfg.mode)
      SOLID:    pix = cfg.color;
      STRIPE:   pix = (x == cfg.stripe_x) ? cfg.color : '0;
      GRADIENT: pix = {x[7:0], x[7:0], y};
      CHECKER:  pix = (x[5] ^ y[5]) ? cfg.color : '0;
      default:  pix = '0;
    endcase
    return pix;
  endfunction

endpackage

// File: rtl/video_pattern_regs.sv
// Avalon-MM register file for the video pattern source.
//   clk, reset_n           - clock, async active-low reset
//   chipselect_i/read_i/write_i, address_i, writedata_i - slave access
//   readdata_o             - registered read data, holds until next read
//   frame_done_i           - one-cycle pulse when an eop beat is accepted
//   busy_i, line_i         - live status from the sequencer
//   enable_o, cfg_o        - current CTRL.enable and pattern configuration
module video_pattern_regs
  import vpat_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic [CSR_W-1:0]  writedata_i,
  output logic [CSR_W-1:0]  readdata_o,
  input  logic              frame_done_i,
  input  logic              busy_i,
  input  logic [15:0]       line_i,
  output logic              enable_o,
  output pat_cfg_t          cfg_o
);

  logic              enable_q, enable_d;
  mode_t             mode_q, mode_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic [15:0]       stripe_q, stripe_d;
  logic [CSR_W-1:0]  frame_count_q, frame_count_d;
  logic [CSR_W-1:0]  readdata_q, readdata_d;

  // Upper write-data bits have no register behind them.
  logic unused_wdata;
  assign unused_wdata = ^writedata_i[CSR_W-1:DATA_W];

  // Register writes and frame counter.
  always_comb begin
    enable_d      = enable_q;
    mode_d        = mode_q;
    color_d       = color_q;
    stripe_d      = stripe_q;
    frame_count_d = frame_count_q + CSR_W'(frame_done_i);
    if (chipselect_i && write_i) begin
      case (address_i)
        ADDR_CTRL: begin
          enable_d = writedata_i[0];
          mode_d   = mode_t'(writedata_i[2:1]);
        end
        ADDR_COLOR:    color_d  = writedata_i[DATA_W-1:0];
        ADDR_STRIPE_X: stripe_d = writedata_i[15:0];
        default: begin end
      endcase
    end
  end

  // Readback mux; the result is captured only on a read strobe.
  always_comb begin
    readdata_d = readdata_q;
    if (chipselect_i && read_i) begin
      case (address_i)
        ADDR_CTRL:        readdata_d = {29'd0, mode_q, enable_q};
        ADDR_COLOR:       readdata_d = {8'd0, color_q};
        ADDR_STRIPE_X:    readdata_d = {16'd0, stripe_q};
        ADDR_FRAME_COUNT: readdata_d = frame_count_q;
        ADDR_STATUS:      readdata_d = {line_i, 15'd0, busy_i};
        default:          readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q      <= 1'b0;
      mode_q        <= SOLID;
      color_q       <= COLOR_RST;
      stripe_q      <= STRIPE_RST;
      frame_count_q <= '0;
      readdata_q    <= '0;
    end else begin
      enable_q      <= enable_d;
      mode_q        <= mode_d;
      color_q       <= color_d;
      stripe_q      <= stripe_d;
      frame_count_q <= frame_count_d;
      readdata_q    <= readdata_d;
    end
  end

  assign readdata_o = readdata_q;
  assign enable_o   = enable_q;
  assign cfg_o      = '{mode: mode_q, color: color_q, stripe_x: stripe_q};

endmodule

// File: rtl/video_pattern_source.sv
// Avalon-ST test-pattern frame generator.
//   clk, reset_n                        - clock, async active-low reset
//   source_data/valid/sop/eop, ready    - Avalon-ST source, ready latency 0
//   s_chipselect/read/write, s_address,
//   s_writedata, s_readdata             - Avalon-MM configuration slave
// Each frame is one header beat (data 0, sop) followed by WIDTH*HEIGHT
// pixels, then GAP_CYCLES idle cycles.
module video_pattern_source
  import vpat_pkg::*;
#(
  parameter int unsigned WIDTH      = 640,
  parameter int unsigned HEIGHT     = 480,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [DATA_W-1:0] source_data,
  output logic              source_valid,
  input  logic              source_ready,
  output logic              source_sop,
  output logic              source_eop,
  input  logic              s_chipselect,
  input  logic              s_read,
  input  logic              s_write,
  input  logic [ADDR_W-1:0] s_address,
  input  logic [CSR_W-1:0]  s_writedata,
  output logic [CSR_W-1:0]  s_readdata
);

  localparam int unsigned X_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned Y_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned G_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [X_W-1:0] X_LAST   = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST   = Y_W'(HEIGHT - 1);
  localparam logic [G_W-1:0] GAP_LOAD = G_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit             HAS_GAP  = (GAP_CYCLES > 0);

  state_t         state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [G_W-1:0] gap_q, gap_d;
  pat_cfg_t       shadow_q, shadow_d;
  beat_t          beat_q, beat_d;
  logic           valid_q, valid_d;

  logic           enable;
  pat_cfg_t       cfg;
  logic           handshake_c;
  logic           last_pix_c;
  logic           frame_done_c;
  logic           ctrl_wr_c;
  logic           enable_at_end_c;

  video_pattern_regs u_regs (
    .clk          (clk),
    .reset_n      (reset_n),
    .chipselect_i (s_chipselect),
    .read_i       (s_read),
    .write_i      (s_write),
    .address_i    (s_address),
    .writedata_i  (s_writedata),
    .readdata_o   (s_readdata),
    .frame_done_i (frame_done_c),
    .busy_i       (state_q != IDLE),
    .line_i       (16'(y_q)),
    .enable_o     (enable),
    .cfg_o        (cfg)
  );

  assign handshake_c = valid_q && source_ready;
  assign last_pix_c  = (x_q == X_LAST) && (y_q == Y_LAST);
  assign ctrl_wr_c   = s_chipselect && s_write && (s_address == ADDR_CTRL);
  // A CTRL write landing on the eop edge must steer the back-to-back decision.
  assign enable_at_end_c = ctrl_wr_c ? s_writedata[0] : enable;

  // Frame sequencer next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (enable) state_d = HEADER;
      HEADER: if (handshake_c) state_d = PIXELS;
      PIXELS: begin
        if (handshake_c && last_pix_c) begin
          if (HAS_GAP)              state_d = GAP;
          else if (enable_at_end_c) state_d = HEADER;
          else                      state_d = IDLE;
        end
      end
      GAP:    if (gap_q == '0) state_d = enable ? HEADER : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters, shadow capture and the next registered beat.
  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    gap_d        = gap_q;
    shadow_d     = shadow_q;
    frame_done_c = 1'b0;
    valid_d      = 1'b0;
    beat_d       = '0;

    if (state_q == HEADER && handshake_c) begin
      x_d = '0;
      y_d = '0;
    end

    if (state_q == PIXELS && handshake_c) begin
      if (last_pix_c) begin
        x_d          = '0;
        y_d          = '0;
        frame_done_c = 1'b1;
      end else if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end

    if (state_q == GAP) gap_d = gap_q - G_W'(1);
    if (state_d == GAP && state_q != GAP) gap_d = GAP_LOAD;

    // Configuration is frozen for the whole frame from header entry on.
    if (state_d == HEADER && state_q != HEADER) shadow_d = cfg;

    // Output registers describe the beat offered in the next state; without
    // a handshake every input here is unchanged, so the beat holds.
    case (state_d)
      HEADER: begin
        valid_d    = 1'b1;
        beat_d.sop = 1'b1;
      end
      PIXELS: begin
        valid_d     = 1'b1;
        beat_d.data = pattern_pixel(shadow_d, 16'(x_d), 8'(y_d));
        beat_d.eop  = (x_d == X_LAST) && (y_d == Y_LAST);
      end
      default: valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      gap_q    <= '0;
      shadow_q <= '0;
      beat_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      gap_q    <= gap_d;
      shadow_q <= shadow_d;
      beat_q   <= beat_d;
      valid_q  <= valid_d;
    end
  end

  assign source_valid = valid_q;
  assign source_data  = beat_q.data;
  assign source_sop   = beat_q.sop;
  assign source_eop   = beat_q.eop;

endmodule

// File: tb/tb_video_pattern_source.sv
// Self-checking bench for video_pattern_source with an 8x4 frame and a
// two-cycle inter-frame gap.
module tb_video_pattern_source;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] source_data;
  logic        source_valid;
  logic        source_ready;
  logic        source_sop;
  logic        source_eop;
  logic        s_chipselect;
  logic        s_read;
  logic        s_write;
  logic [2:0]  s_address;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;

  video_pattern_source #(.WIDTH(W), .HEIGHT(H), .GAP_CYCLES(GAP)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .source_data  (source_data),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .s_chipselect (s_chipselect),
    .s_read       (s_read),
    .s_write      (s_write),
    .s_address    (s_address),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] d;
    logic        s;
    logic        e;
  } tb_beat_t;

  int n_cmp  = 0;
  int n_fail = 0;

  // Bench mirror of the writable registers.
  logic        m_en;
  int          m_mode;
  logic [23:0] m_color;
  int          m_stripe;

  tb_beat_t    exp_q[$];
  logic [23:0] frame_buf [0:63];
  int          beat_idx = 0;
  int          eop_cnt  = 0;
  logic        gap_chk  = 1'b0;
  logic        rnd_ready = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Pixel value straight from the pattern rules.
  function automatic logic [23:0] ref_pix(input int m, input logic [23:0] c,
                                          input int s, input int x, input int y);
    logic [31:0] xv;
    logic [31:0] yv;
    xv = x;
    yv = y;
    case (m)
      0:       return c;
      1:       return (x == s) ? c : 24'h0;
      2:       return {xv[7:0], xv[7:0], yv[7:0]};
      default: return (xv[5] ^ yv[5]) ? c : 24'h0;
    endcase
  endfunction

  task automatic push_frame();
    tb_beat_t b;
    b.d = 24'h0; b.s = 1'b1; b.e = 1'b0;
    exp_q.push_back(b);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        b.d = ref_pix(m_mode, m_color, m_stripe, x, y);
        b.s = 1'b0;
        b.e = (x == W - 1) && (y == H - 1);
        exp_q.push_back(b);
      end
  endtask

  // Ready is changed just after each edge so the compare process sees the
  // value used at the next edge.
  initial begin
    source_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      source_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Stream checker: scoreboard, stall stability and inter-frame gap.
  logic        prev_hdr = 1'b0;
  logic        prev_stall = 1'b0;
  logic [23:0] p_data;
  logic        p_sop, p_eop;
  logic        in_gap = 1'b0;
  int          idle = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      prev_hdr   = 1'b0;
      prev_stall = 1'b0;
      in_gap     = 1'b0;
      idle       = 0;
      beat_idx   = 0;
      eop_cnt    = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, source_valid}, 32'd1);
        chk("stall_data", {8'd0, source_data}, {8'd0, p_data});
        chk("stall_sop", {31'd0, source_sop}, {31'd0, p_sop});
        chk("stall_eop", {31'd0, source_eop}, {31'd0, p_eop});
      end
      if (source_valid && source_sop && !prev_hdr) begin
        if (in_gap && gap_chk) chk("gap_len", idle, GAP);
        in_gap = 1'b0;
        push_frame();
      end
      if (in_gap && !source_valid) idle++;
      if (source_valid && source_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %h sop %b eop %b, expected no beat",
                   source_data, source_sop, source_eop);
        end else begin
          tb_beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", {8'd0, source_data}, {8'd0, e.d});
          chk("beat_sop", {31'd0, source_sop}, {31'd0, e.s});
          chk("beat_eop", {31'd0, source_eop}, {31'd0, e.e});
        end
        if (beat_idx < 64) frame_buf[beat_idx] = source_data;
        beat_idx++;
        if (source_eop) begin
          eop_cnt++;
          beat_idx = 0;
          in_gap   = 1'b1;
          idle     = 0;
        end
      end
      prev_hdr   = source_valid && source_sop;
      prev_stall = source_valid && !source_ready;
      p_data     = source_data;
      p_sop      = source_sop;
      p_eop      = source_eop;
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    s_chipselect = 1'b1; s_write = 1'b1; s_address = a; s_writedata = d;
    @(posedge clk);
    #1;
    s_chipselect = 1'b0; s_write = 1'b0;
    case (a)
      3'd0: begin m_en = d[0]; m_mode = int'(d[2:1]); end
      3'd1: m_color = d[23:0];
      3'd2: m_stripe = int'(d[15:0]);
      default: begin end
    endcase
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    @(posedge clk);
    #1;
    s_chipselect = 1'b1; s_read = 1'b1; s_address = a;
    @(posedge clk);
    #1;
    s_chipselect = 1'b0; s_read = 1'b0;
    v = s_readdata;
  endtask

  task automatic wait_eops(input int n, input string nm);
    int t = 0;
    while (eop_cnt < n && t < 2000) begin
      @(posedge clk);
      t++;
    end
    chk({"wait_", nm}, {31'd0, eop_cnt >= n}, 32'd1);
  endtask

  task automatic wait_beats(input int n, input string nm);
    int t = 0;
    while (beat_idx != n && t < 2000) begin
      @(posedge clk);
      t++;
    end
    chk({"wait_", nm}, beat_idx, n);
  endtask

  task automatic mirror_defaults();
    m_en = 1'b0; m_mode = 0; m_color = 24'hFFFFFF; m_stripe = 31;
  endtask

  logic [31:0] v;
  int          e;

  initial begin
    reset_n = 1'b0;
    s_chipselect = 1'b0; s_read = 1'b0; s_write = 1'b0;
    s_address = 3'd0; s_writedata = 32'd0;
    mirror_defaults();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, source_valid}, 32'd0);
    chk("rst_sop", {31'd0, source_sop}, 32'd0);
    chk("rst_eop", {31'd0, source_eop}, 32'd0);
    chk("rst_data", {8'd0, source_data}, 32'd0);
    chk("rst_readdata", s_readdata, 32'd0);
    reset_n = 1'b1;

    rd(3'd0, v); chk("rd_ctrl_rst", v, 32'h0);
    rd(3'd1, v); chk("rd_color_rst", v, 32'h00FFFFFF);
    rd(3'd2, v); chk("rd_stripe_rst", v, 32'd31);
    rd(3'd3, v); chk("rd_fc_rst", v, 32'd0);
    rd(3'd4, v); chk("rd_status_rst", v, 32'd0);
    rd(3'd5, v); chk("rd_addr5", v, 32'd0);
    wr(3'd3, 32'h55); rd(3'd3, v); chk("fc_ro", v, 32'd0);

    // Enable: header is offered in the cycle after the edge following the write.
    gap_chk = 1'b1;
    wr(3'd0, 32'h1);
    @(negedge clk); chk("lat_early_valid", {31'd0, source_valid}, 32'd0);
    @(negedge clk);
    chk("lat_valid", {31'd0, source_valid}, 32'd1);
    chk("lat_sop", {31'd0, source_sop}, 32'd1);
    chk("lat_data", {8'd0, source_data}, 32'd0);
    wait_eops(1, "frame1");
    chk("solid_px0", {8'd0, frame_buf[1]}, 32'hFFFFFF);
    chk("solid_last", {8'd0, frame_buf[32]}, 32'hFFFFFF);
    rd(3'd3, v); chk("fc_one", v, 32'd1);

    // Stripe at x = 3.
    wait_beats(3, "stripe_start");
    wr(3'd1, 32'hFF); wr(3'd2, 32'd3); wr(3'd0, 32'h3);
    e = eop_cnt;
    wait_eops(e + 2, "stripe");
    chk("stripe_x3y2", {8'd0, frame_buf[20]}, 32'h0000FF);
    chk("stripe_x4y2", {8'd0, frame_buf[21]}, 32'h0);
    chk("stripe_x2y2", {8'd0, frame_buf[19]}, 32'h0);

    // Gradient.
    wait_beats(3, "grad_start");
    wr(3'd0, 32'h5);
    e = eop_cnt;
    wait_eops(e + 2, "gradient");
    chk("grad_x5y3", {8'd0, frame_buf[30]}, 32'h050503);
    chk("grad_x7y3", {8'd0, frame_buf[32]}, 32'h070703);
    chk("grad_x0y1", {8'd0, frame_buf[9]}, 32'h000001);

    // Checker: bit 5 of x and y is always 0 in an 8x4 frame.
    wait_beats(3, "chk_start");
    wr(3'd0, 32'h7);
    e = eop_cnt;
    wait_eops(e + 2, "checker");
    chk("checker_px", {8'd0, frame_buf[13]}, 32'h0);

    // Solid 0xFF under random backpressure.
    wait_beats(3, "rnd_start");
    wr(3'd0, 32'h1);
    rnd_ready = 1'b1;
    e = eop_cnt;
    wait_eops(e + 3, "random_ready");
    rnd_ready = 1'b0;
    chk("rnd_px", {8'd0, frame_buf[5]}, 32'h0000FF);

    // Colour change mid-frame applies from the next frame only.
    wait_beats(5, "color_start");
    wr(3'd1, 32'h123456);
    e = eop_cnt;
    wait_eops(e + 1, "color_old");
    chk("color_old_last", {8'd0, frame_buf[32]}, 32'h0000FF);
    wait_eops(e + 2, "color_new");
    chk("color_new_first", {8'd0, frame_buf[1]}, 32'h123456);
    chk("color_new_last", {8'd0, frame_buf[32]}, 32'h123456);

    // Disable at pixel 10: frame completes, then the source goes idle.
    wait_beats(11, "dis_start");
    wr(3'd0, 32'h0);
    gap_chk = 1'b0;
    e = eop_cnt;
    wait_eops(e + 1, "disable");
    repeat (8) @(posedge clk);
    rd(3'd4, v); chk("status_busy", {31'd0, v[0]}, 32'd0);
    rd(3'd3, v); chk("fc_model", v, eop_cnt);
    chk("fc_literal", v, 32'd13);
    @(negedge clk);
    chk("idle_valid", {31'd0, source_valid}, 32'd0);
    chk("sb_empty", exp_q.size(), 32'd0);

    // Reset mid-frame.
    wr(3'd0, 32'h1);
    wait_beats(10, "reset_start");
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, source_valid}, 32'd0);
    chk("midrst_eop", {31'd0, source_eop}, 32'd0);
    chk("midrst_data", {8'd0, source_data}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    mirror_defaults();
    rd(3'd3, v); chk("rst_fc", v, 32'd0);
    rd(3'd0, v); chk("rst_ctrl", v, 32'd0);
    rd(3'd1, v); chk("rst_color", v, 32'h00FFFFFF);
    @(negedge clk);
    chk("post_rst_valid", {31'd0, source_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/video_pattern_source.md
# video_pattern_source

Avalon-ST video packet transmitter: generates complete frames (one header beat, then WIDTH×HEIGHT 24-bit pixels) from a programmable test pattern. Observes `source_ready` backpressure. Drives the sink of video filters such as the edge-binning block on-chip, replacing camera input for bring-up and regression. Configured and monitored through a small Avalon-MM slave.

## Interface
Parameters:
- `WIDTH`, 640: pixels per line.
- `HEIGHT`, 480: lines per frame.
- `GAP_CYCLES`, 16: idle cycles between the end of one frame and the next header; 0 is legal.

Ports:
- `clk`, in, 1: single clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `source_data`, out, 24: header word or pixel, {R,G,B}.
- `source_valid`, out, 1: beat valid.
- `source_ready`, in, 1: downstream accepts; ready latency 0.
- `source_sop`, out, 1: high on the header beat only.
- `source_eop`, out, 1: high on the last pixel beat only.
- `s_chipselect`, `s_read`, `s_write`, in, 1 each: Avalon-MM slave controls.
- `s_address`, in, 3: word address.
- `s_writedata`, in, 32: write data.
- `s_readdata`, out, 32: read data, registered.

## Operation
- Registers:
  - 0 CTRL, RW, reset 0: bit0 `enable`; bits2:1 `mode`.
  - 1 COLOR, RW, reset 0x00FFFFFF: bits23:0.
  - 2 STRIPE_X, RW, reset 31: bits15:0.
  - 3 FRAME_COUNT, RO: frames completed (beat with eop accepted), 32-bit, wraps.
  - 4 STATUS, RO: bit0 `busy` (state ≠ IDLE); bits 31:16 are the current line `y`.
  - Addresses 5–7 read 0.
  - Writes to RO or unused addresses are ignored.
- Shadow copy: `mode`, `COLOR` and `STRIPE_X` are copied into shadow registers on entry to HEADER. Register writes made mid-frame never affect the frame in flight.
- FSM states IDLE → HEADER → PIXELS → GAP → HEADER/IDLE:
  - IDLE: `source_valid` = 0. Go to HEADER when `enable` = 1.
  - HEADER: drive `source_data` = 0 with `source_sop` = 1. On handshake go to PIXELS with x = 0, y = 0.
  - PIXELS: drive the pixel at (x, y). x increments on each handshake and wraps at WIDTH−1, at which point y increments. `source_eop` = 1 at (WIDTH−1, HEIGHT−1). When that beat is accepted, FRAME_COUNT increments and the FSM goes to GAP, or to HEADER if GAP_CYCLES = 0 and `enable` = 1, or to IDLE if GAP_CYCLES = 0 and `enable` = 0.
  - GAP: down-counter runs for GAP_CYCLES. At expiry go to HEADER if `enable`, else IDLE.
- Clearing `enable` mid-frame completes the current frame; frames are never truncated.
- Pixel function of the shadow mode:
  - 0: COLOR.
  - 1: COLOR if x == STRIPE_X, else 0.
  - 2: {x[7:0], x[7:0], y[7:0]}.
  - 3: COLOR if x[5]^y[5], else 0.
- Width rules: x and y are `$clog2` of WIDTH and HEIGHT wide, zero-extended into STATUS.

## Timing
- All outputs are registered. Reset values:
  - `source_valid`, `source_sop`, `source_eop`: 0.
  - `source_data`: 0.
  - `s_readdata`: 0.
  - FSM in IDLE; all counters 0.
- Handshake occurs when `source_valid` && `source_ready` at a rising edge.
- While `source_valid` && !`source_ready`, `source_data`, `source_sop` and `source_eop` hold stable.
- `source_valid` never drops without a handshake, except on reset.
- Enable latency: CTRL write with `enable` = 1 captured at edge E → state HEADER at edge E+1 → header beat valid in the cycle after E+1.
- Throughput: with `source_ready` held high, one beat per cycle. A frame is 1 + WIDTH×HEIGHT beats, followed by GAP_CYCLES idle cycles.
- Read latency: `s_readdata` is valid on the cycle after `s_chipselect` && `s_read`, and holds until the next read.
- Simultaneous write to CTRL and frame end: the new `enable` value decides the GAP/HEADER/IDLE decision on the following cycle.
- Reset asserted mid-frame: outputs go to reset values immediately. No eop is emitted. FRAME_COUNT returns to 0.

## Structure
- Package `vpat_pkg`:
  - `mode_t` enum (SOLID, STRIPE, GRADIENT, CHECKER).
  - `state_t` enum (IDLE, HEADER, PIXELS, GAP).
  - Register address constants `ADDR_CTRL` … `ADDR_STATUS`.
- Sub-module `video_pattern_regs`: Avalon-MM register file and readback mux. The top level holds the FSM, the x/y/gap counters and the pixel function.

## Test plan
- WIDTH=8, HEIGHT=4, GAP_CYCLES=2, `source_ready` = 1, write CTRL = 0x1 → header beat (data 0, sop) 2 cycles after the write; 32 pixels of 0xFFFFFF; eop on beat 33; 2 idle cycles; next sop; FRAME_COUNT = 1.
- Defaults, mode 1 (CTRL = 0x3), STRIPE_X = 31, COLOR = 0xFF → per line, only x = 31 carries 0x0000FF; 307,201 beats per frame; eop at (639,479).
- WIDTH=8, HEIGHT=4, random `source_ready` (50%) → beats match the ready-always-high reference sequence exactly; data/sop/eop stable during stalls.
- Clear `enable` at pixel 10 of a frame → frame completes with eop; FSM reaches IDLE; STATUS.busy = 0; FRAME_COUNT increments once.
- Write COLOR = 0x123456 mid-frame in mode 0 → rest of the current frame keeps the old color; the next frame is all 0x123456.
- Assert `reset_n` = 0 mid-frame → `source_valid` = 0 immediately; FRAME_COUNT reads 0 after release; CTRL reads 0.
